// File: rtl/bht_update_ctrl.sv
// Gshare pattern-history-table sequencer: forms lookup indices, tracks in-flight
// predictions, applies 2-bit saturating updates at resolve and recovers history on mispredict.
module bht_update_ctrl #(
    parameter int INDEX = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_stall,
    input  logic             fetch_valid,
    input  logic [31:0]      fetch_pc,
    output logic             fetch_ready,
    output logic             pred_valid,
    output logic             pred_taken,
    input  logic             resolve_valid,
    input  logic             resolve_taken,
    output logic             mispredict,
    output logic [INDEX-1:0] pht_rd_index,
    input  logic [1:0]       pht_rd_counter,
    output logic             pht_wr_en,
    output logic [INDEX-1:0] pht_wr_index,
    output logic [1:0]       pht_wr_data,
    output logic             init_busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        else       return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

    logic             init_busy_q;
    logic [INDEX-1:0] sweep_q;
    logic [INDEX-1:0] ghr_spec_q;
    logic [INDEX-1:0] ghr_commit_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    logic [INDEX-1:0] fifo_idx  [DEPTH];
    logic [1:0]       fifo_ctr  [DEPTH];
    logic             fifo_pred [DEPTH];

    logic             wr_vld_p1;
    logic [INDEX-1:0] wr_idx_p1;
    logic [1:0]       wr_data_p1;

    logic             active;
    logic             full;
    logic             empty;
    logic [1:0]       eff_ctr;
    logic             accept;
    logic             push;
    logic             unused_pc;

    assign unused_pc = ^{fetch_pc[31:INDEX+2], fetch_pc[1:0]};

    // While rst is asserted the controller is inert: no writes, no requests, no resolves.
    assign active    = !rst && !init_busy_q;
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign init_busy = init_busy_q;

    assign pht_wr_en    = !rst && (init_busy_q || wr_vld_p1);
    assign pht_wr_index = init_busy_q ? sweep_q : wr_idx_p1;
    assign pht_wr_data  = init_busy_q ? 2'b01   : wr_data_p1;

    assign pht_rd_index = fetch_pc[INDEX+1:2] ^ ghr_spec_q;
    assign eff_ctr      = (pht_wr_en && (pht_wr_index == pht_rd_index)) ? pht_wr_data
                                                                        : pht_rd_counter;

    assign fetch_ready = active && !full;
    assign pred_valid  = fetch_valid && fetch_ready && !mem_stall;
    assign pred_taken  = active && eff_ctr[1];
    assign accept      = active && resolve_valid && !empty && !mem_stall;
    assign mispredict  = accept && (resolve_taken != fifo_pred[rd_ptr_q]);
    assign push        = pred_valid && !mispredict;

    always_ff @(posedge clk) begin
        if (rst) begin
            init_busy_q  <= 1'b1;
            sweep_q      <= '0;
            ghr_spec_q   <= '0;
            ghr_commit_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            wr_vld_p1    <= 1'b0;
        end else begin
            if (init_busy_q) begin
                sweep_q <= sweep_q + INDEX'(1);
                if (&sweep_q) init_busy_q <= 1'b0;
            end
            wr_vld_p1 <= accept;
            if (accept) ghr_commit_q <= {ghr_commit_q[INDEX-2:0], resolve_taken};
            if (mispredict) begin
                // Restart speculation from architectural history plus this outcome.
                ghr_spec_q <= {ghr_commit_q[INDEX-2:0], resolve_taken};
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q   <= wr_ptr_q + PW'(1);
                    ghr_spec_q <= {ghr_spec_q[INDEX-2:0], eff_ctr[1]};
                end
                if (accept) rd_ptr_q <= rd_ptr_q + PW'(1);
                unique case ({push, accept})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: ;
                endcase
            end
        end
    end

    // Stage p1: counter update computed at resolve, written to the PHT one cycle later.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx[wr_ptr_q]  <= pht_rd_index;
            fifo_ctr[wr_ptr_q]  <= eff_ctr;
            fifo_pred[wr_ptr_q] <= eff_ctr[1];
        end
        if (accept) begin
            wr_idx_p1  <= fifo_idx[rd_ptr_q];
            wr_data_p1 <= sat_update(fifo_ctr[rd_ptr_q], resolve_taken);
        end
    end

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Bench for bht_update_ctrl: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_bht_update_ctrl;
    localparam int INDEX = 4;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        mem_stall;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic        pred_valid;
    logic        pred_taken;
    logic        resolve_valid;
    logic        resolve_taken;
    logic        mispredict;
    logic [3:0]  pht_rd_index;
    logic [1:0]  pht_rd_counter;
    logic        pht_wr_en;
    logic [3:0]  pht_wr_index;
    logic [1:0]  pht_wr_data;
    logic        init_busy;

    bht_update_ctrl #(.INDEX(INDEX), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .mem_stall(mem_stall),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .mispredict(mispredict),
        .pht_rd_index(pht_rd_index), .pht_rd_counter(pht_rd_counter),
        .pht_wr_en(pht_wr_en), .pht_wr_index(pht_wr_index), .pht_wr_data(pht_wr_data),
        .init_busy(init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // PHT storage seen by the DUT; start with non-01 contents so the sweep matters.
    logic [1:0] env_pht [16];
    logic       force_en;
    logic [1:0] force_val;
    initial for (int i = 0; i < 16; i++) env_pht[i] = 2'b11;
    always @(posedge clk) if (pht_wr_en) env_pht[pht_wr_index] <= pht_wr_data;
    assign pht_rd_counter = force_en ? force_val : env_pht[pht_rd_index];

    // Reference model
    typedef struct { logic [3:0] idx; logic [1:0] ctr; logic pred; } ent_t;
    ent_t       mq[$];
    logic [1:0] m_pht [16];
    logic       m_init  = 1'b1;
    int         m_sweep = 0;
    logic [3:0] m_gs    = '0;
    logic [3:0] m_gc    = '0;
    logic       m_pend  = 1'b0;
    logic [3:0] m_pidx  = '0;
    logic [1:0] m_pdata = '0;
    logic       model_on = 1'b0;

    always @(negedge clk) begin : model
        logic [3:0] e_idx, e_widx, gc_next;
        logic [1:0] e_wdata, e_eff;
        logic       e_wen, e_ready, e_pv, e_pt, e_acc, e_mis, e_push;
        int         c;
        if (model_on) begin
            if (rst) begin
                check("m_rst_wr_en", pht_wr_en, 0);
                check("m_rst_ready", fetch_ready, 0);
                check("m_rst_pred_valid", pred_valid, 0);
                check("m_rst_pred_taken", pred_taken, 0);
                check("m_rst_mispredict", mispredict, 0);
                check("m_rst_init_busy", init_busy, m_init);
                m_init = 1'b1; m_sweep = 0; m_gs = '0; m_gc = '0; m_pend = 1'b0;
                mq.delete();
            end else begin
                e_wen   = m_init || m_pend;
                e_widx  = m_init ? m_sweep[3:0] : m_pidx;
                e_wdata = m_init ? 2'b01 : m_pdata;
                e_idx   = fetch_pc[5:2] ^ m_gs;
                if (e_wen && e_widx == e_idx) e_eff = e_wdata;
                else                          e_eff = force_en ? force_val : m_pht[e_idx];
                e_ready = !m_init && (mq.size() < DEPTH);
                e_pv    = fetch_valid && e_ready && !mem_stall;
                e_pt    = !m_init && e_eff[1];
                e_acc   = resolve_valid && (mq.size() > 0) && !mem_stall && !m_init;
                e_mis   = e_acc && (resolve_taken != mq[0].pred);
                e_push  = e_pv && !e_mis;

                check("m_init_busy", init_busy, m_init);
                check("m_fetch_ready", fetch_ready, e_ready);
                check("m_pred_valid", pred_valid, e_pv);
                check("m_pred_taken", pred_taken, e_pt);
                check("m_mispredict", mispredict, e_mis);
                check("m_rd_index", pht_rd_index, e_idx);
                check("m_wr_en", pht_wr_en, e_wen);
                if (e_wen) begin
                    check("m_wr_index", pht_wr_index, e_widx);
                    check("m_wr_data", pht_wr_data, e_wdata);
                end

                if (e_wen) m_pht[e_widx] = e_wdata;
                gc_next = m_gc;
                if (e_acc) begin
                    c = int'(mq[0].ctr);
                    if (resolve_taken) c = (c < 3) ? c + 1 : 3;
                    else               c = (c > 0) ? c - 1 : 0;
                    m_pidx  = mq[0].idx;
                    m_pdata = 2'(c);
                    gc_next = {m_gc[2:0], resolve_taken};
                end
                m_pend = e_acc;
                if (e_mis) begin
                    mq.delete();
                    m_gs = {m_gc[2:0], resolve_taken};
                end else begin
                    if (e_acc) void'(mq.pop_front());
                    if (e_push) begin
                        mq.push_back('{idx: e_idx, ctr: e_eff, pred: e_eff[1]});
                        m_gs = {m_gs[2:0], e_eff[1]};
                    end
                end
                m_gc = gc_next;
                if (m_init) begin
                    if (m_sweep == 15) m_init = 1'b0;
                    m_sweep++;
                end
            end
        end
    end

    logic [3:0] g;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // One branch at a fixed PHT index: predict, resolve next cycle, expect the write after.
    task automatic do_branch(input logic [3:0] idx, input logic taken, input logic [1:0] exp_data);
        fetch_valid = 1'b1;
        fetch_pc    = 32'(idx ^ g) << 2;
        @(negedge clk);
        check("br_rd_index", pht_rd_index, idx);
        check("br_pred_valid", pred_valid, 1);
        check("br_idle_wr_en", pht_wr_en, 0);
        tick();
        fetch_valid   = 1'b0;
        resolve_valid = 1'b1;
        resolve_taken = taken;
        @(negedge clk);
        check("br_resolve_wr_en", pht_wr_en, 0);
        tick();
        resolve_valid = 1'b0;
        @(negedge clk);
        check("br_wr_en", pht_wr_en, 1);
        check("br_wr_index", pht_wr_index, idx);
        check("br_wr_data", pht_wr_data, exp_data);
        g = {g[2:0], taken};
        tick();
    endtask

    initial begin
        rst = 1'b1; mem_stall = 1'b0; fetch_valid = 1'b0; fetch_pc = '0;
        resolve_valid = 1'b0; resolve_taken = 1'b0; force_en = 1'b0; force_val = 2'b00;
        g = 4'b0000;

        // Reset and full sweep
        tick();
        model_on = 1'b1;
        @(negedge clk);
        check("rst_init_busy", init_busy, 1);
        check("rst_wr_en", pht_wr_en, 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("sweep1_idx", pht_wr_index, k);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("sweep_en", pht_wr_en, 1);
            check("sweep_idx", pht_wr_index, k);
            check("sweep_data", pht_wr_data, 2'b01);
            check("sweep_busy", init_busy, 1);
            check("sweep_ready", fetch_ready, 0);
            tick();
        end

        // Mispredict recovery
        fetch_valid = 1'b1;
        fetch_pc    = 32'h10;
        @(negedge clk);
        check("post_sweep_ready", fetch_ready, 1);
        check("post_sweep_busy", init_busy, 0);
        check("mp_rd_index", pht_rd_index, 4);
        check("mp_pred_taken", pred_taken, 0);
        tick();
        fetch_valid   = 1'b0;
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        @(negedge clk);
        check("mp_mispredict", mispredict, 1);
        tick();
        fetch_pc = 32'h0;
        @(negedge clk);
        check("mp_wr_en", pht_wr_en, 1);
        check("mp_wr_index", pht_wr_index, 4);
        check("mp_wr_data", pht_wr_data, 2'b10);
        check("mp_ghr_spec", pht_rd_index, 4'b0001);
        check("mp_empty_drop", mispredict, 0);
        tick();
        resolve_valid = 1'b0;
        @(negedge clk);
        check("mp_drop_no_wr", pht_wr_en, 0);
        tick();
        g = 4'b0001;

        // Saturation on index 9
        do_branch(4'd9, 1'b1, 2'b10);
        do_branch(4'd9, 1'b1, 2'b11);
        do_branch(4'd9, 1'b1, 2'b11);
        do_branch(4'd9, 1'b0, 2'b10);
        do_branch(4'd9, 1'b0, 2'b01);
        do_branch(4'd9, 1'b0, 2'b00);
        do_branch(4'd9, 1'b0, 2'b00);

        // Full FIFO and occupancy with simultaneous push/pop
        fetch_valid = 1'b1;
        fetch_pc    = 32'h0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("fill_ready", fetch_ready, 1);
            tick();
        end
        resolve_valid = 1'b1;
        resolve_taken = 1'b0;
        @(negedge clk);
        check("full_ready", fetch_ready, 0);
        check("full_pred_valid", pred_valid, 0);
        check("full_mispredict", mispredict, 0);
        tick();
        @(negedge clk);
        check("after_pop_ready", fetch_ready, 1);
        check("after_pop_pred_valid", pred_valid, 1);
        tick();
        resolve_valid = 1'b0;
        @(negedge clk);
        check("pushpop_ready", fetch_ready, 1);
        tick();
        fetch_valid   = 1'b0;
        resolve_valid = 1'b1;
        @(negedge clk);
        check("refull_ready", fetch_ready, 0);
        tick();
        tick(); tick(); tick();
        resolve_valid = 1'b0;
        tick();
        @(negedge clk);
        check("drained_ready", fetch_ready, 1);
        tick();

        // mem_stall freeze
        fetch_valid = 1'b1;
        tick();
        mem_stall     = 1'b1;
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        @(negedge clk);
        check("stall_pred_valid", pred_valid, 0);
        check("stall_mispredict", mispredict, 0);
        tick();
        @(negedge clk);
        check("stall_wr_en", pht_wr_en, 0);
        check("stall_ghr", pht_rd_index, 0);
        tick();
        mem_stall = 1'b0;
        @(negedge clk);
        check("unstall_mispredict", mispredict, 1);
        check("unstall_pred_valid", pred_valid, 1);
        tick();
        mem_stall     = 1'b1;
        fetch_valid   = 1'b0;
        resolve_valid = 1'b0;
        @(negedge clk);
        check("stall_issued_wr_en", pht_wr_en, 1);
        check("stall_issued_wr_idx", pht_wr_index, 0);
        check("stall_issued_wr_data", pht_wr_data, 2'b01);
        check("recover_ghr", pht_rd_index, 4'b0001);
        tick();
        mem_stall = 1'b0;
        tick();
        g = 4'b0001;

        // Write-to-read bypass on index 5
        do_branch(4'd5, 1'b1, 2'b10);
        fetch_valid = 1'b1;
        fetch_pc    = 32'(4'd5 ^ 4'b0011) << 2;
        @(negedge clk);
        check("byp_pre_idx", pht_rd_index, 5);
        check("byp_pre_taken", pred_taken, 1);
        tick();
        fetch_valid   = 1'b0;
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        @(negedge clk);
        check("byp_correct", mispredict, 0);
        tick();
        resolve_valid = 1'b0;
        fetch_valid   = 1'b1;
        fetch_pc      = 32'(4'd5 ^ 4'b0111) << 2;
        force_en      = 1'b1;
        force_val     = 2'b00;
        @(negedge clk);
        check("byp_wr_data", pht_wr_data, 2'b11);
        check("byp_rd_index", pht_rd_index, 5);
        check("byp_pred_taken", pred_taken, 1);
        tick();
        fetch_valid   = 1'b0;
        resolve_valid = 1'b1;
        @(negedge clk);
        check("nobyp_pred_taken", pred_taken, 0);
        check("byp_entry_correct", mispredict, 0);
        tick();
        resolve_valid = 1'b0;
        force_en      = 1'b0;
        @(negedge clk);
        check("byp_final_wr_idx", pht_wr_index, 5);
        check("byp_final_wr_data", pht_wr_data, 2'b11);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bht_update_ctrl.md
Name: bht_update_ctrl

Overview:
Controller that sequences the 2-bit pattern history table (PHT) for the fetch and execute stages.
- Forms gshare lookup indices and drives PHT read/write ports.
- Tracks in-flight predicted branches in a FIFO.
- Applies saturating-counter updates at resolution, maintains speculative and committed global history, and recovers on mispredict.
- Initialises every PHT entry to weakly-not-taken after reset.

Parameters:
INDEX, 4, PHT index width; PHT has 2**INDEX entries; GHR width = INDEX (INDEX >= 2).
DEPTH, 4, in-flight branch FIFO entries (power of 2).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_stall  in  1  pipeline freeze
fetch_valid  in  1  fetch stage presents a branch for prediction
fetch_pc  in  32  branch PC
fetch_ready  out  1  controller can accept a prediction request
pred_valid  out  1  fetch_valid && fetch_ready && !mem_stall
pred_taken  out  1  predicted direction (MSB of effective counter)
resolve_valid  in  1  execute resolves the oldest in-flight branch
resolve_taken  in  1  actual direction
mispredict  out  1  resolve accepted and resolve_taken != recorded prediction
pht_rd_index  out  INDEX  combinational lookup index
pht_rd_counter  in  2  PHT counter at pht_rd_index (combinational read)
pht_wr_en  out  1  PHT write strobe
pht_wr_index  out  INDEX  write index
pht_wr_data  out  2  write counter value
init_busy  out  1  reset sweep in progress

Behaviour:
- Reset and init:
  - rst (any cycle, including mid-sweep or mid-operation) clears ghr_spec, ghr_commit, the FIFO and the sweep counter. It sets init_busy=1 and pht_wr_en=0 in the following cycle.
  - Sweep: one write per cycle, index 0..2**INDEX-1, data 2'b01. Writes are not gated by mem_stall.
  - init_busy drops the cycle after the last write.
  - While init_busy: fetch_ready=0, pred_valid=0, resolve_valid ignored, mispredict=0.
- Index formation: pht_rd_index = fetch_pc[INDEX+1:2] XOR ghr_spec.
- Bypass: if pht_wr_en is high this cycle and pht_wr_index == pht_rd_index, the effective counter is pht_wr_data; otherwise it is pht_rd_counter. pred_taken = effective[1].
- fetch_ready = !init_busy && !full. Occupancy counts freed by a same-cycle pop do not make fetch_ready high.
- Push occurs on pred_valid and !mispredict:
  - FIFO entry = {index, effective counter, pred_taken}.
  - ghr_spec <= {ghr_spec[INDEX-2:0], pred_taken}.
- Resolve is accepted when resolve_valid && !empty && !mem_stall && !init_busy; otherwise it is ignored.
  - resolve_valid with an empty FIFO is silently dropped.
  - On accept, pop the head.
  - new = head counter saturating-incremented if taken (11 stays 11), saturating-decremented if not taken (00 stays 00).
  - Next cycle: pht_wr_en=1, pht_wr_index=head index, pht_wr_data=new.
  - ghr_commit <= {ghr_commit[INDEX-2:0], resolve_taken}.
- mispredict is combinational in the resolve-accept cycle. On mispredict:
  - FIFO flushed (empty next cycle).
  - ghr_spec <= {ghr_commit[INDEX-2:0], resolve_taken}.
  - A same-cycle fetch push is suppressed and its ghr_spec shift discarded. pred_valid may still be high; the fetch stage discards that prediction.
- Simultaneous push and correct resolve: both occur; occupancy is unchanged.
- mem_stall freezes the FIFO, both GHRs and the sweep is unaffected:
  - no push, no pop;
  - pht_wr_en=0 outside init;
  - a registered write already issued completes.
- pht_wr_en is low in every cycle except sweep cycles and cycles following an accepted resolve.
- Reset values: fetch_ready=0, pred_valid=0, pred_taken=0, mispredict=0, pht_wr_en=0, init_busy=1 (until the sweep finishes).

Test Plan:
1. Reset sweep, INDEX=4: pulse rst -> init_busy=1 and pht_wr_en=1 for 16 consecutive cycles with indices 0..15, data 01; fetch_ready=1 on cycle 17. Re-assert rst at sweep cycle 7 -> sweep restarts at index 0.
2. Mispredict recovery:
   - Stimulus: after init, fetch_pc=0x10, ghr=0.
   - Required: pht_rd_index=4, counter 01, pred_taken=0.
   - Then resolve_taken=1 -> mispredict=1; next cycle pht_wr_en=1, index 4, data 10; FIFO empty; ghr_spec=ghr_commit=0001.
3. Saturation: repeated taken resolves on one index -> writes 10, 11, 11. Repeated not-taken -> 10, 01, 00, 00. Each write is issued exactly one cycle after its resolve.
4. Full: DEPTH=4 pushes with no resolve -> fetch_ready=0 after the 4th. A correct resolve in the 5th cycle pops; fetch_ready=1 in the 6th. A push and a correct resolve in the same cycle hold occupancy constant.
5. mem_stall: assert with fetch_valid=1 and resolve_valid=1 -> pred_valid=0, no pop, no write, GHRs unchanged. Deassert -> the operations proceed normally.
6. Bypass: a lookup whose index equals the index of an in-progress pht_wr_en with data 11 -> pred_taken=1 even though pht_rd_counter=00.
